// File: rtl/mux_scan_seq.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_seq
// Description : Registered N-channel, W-bit mux with manual select and
//               round-robin scan (programmable dwell, skip mask, frame pulse).
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_seq #(
  parameter int N_CH  = 16,
  parameter int W     = 1,
  parameter int SEL_W = 4,
  parameter int DWELL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] D,
  input  logic [SEL_W-1:0]  S,
  input  logic              mode,
  input  logic              en,
  input  logic [N_CH-1:0]   skip_mask,
  output logic [W-1:0]      Y,
  output logic              Y_valid,
  output logic [SEL_W-1:0]  ch_out,
  output logic              frame_done
);

  localparam logic [SEL_W:0] C_N_CH       = (SEL_W+1)'(N_CH);
  localparam logic [7:0]     C_DWELL_LAST = 8'(DWELL - 1);

  logic [W-1:0]     w_ch [N_CH];
  logic [SEL_W-1:0] w_cur_ptr;
  logic [7:0]       w_cur_dwell;
  logic             w_cur_masked;
  logic             w_advance;
  logic [SEL_W:0]   w_idx;
  logic [SEL_W-1:0] w_nxt;
  logic             w_found;
  logic             w_s_ok;

  logic [W-1:0]     r_y;
  logic             r_y_valid;
  logic [SEL_W-1:0] r_ch;
  logic             r_frame_done;
  logic [SEL_W-1:0] r_ptr;
  logic [7:0]       r_dwell;
  logic             r_scan_prev;

  generate
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
      assign w_ch[k] = D[k*W +: W];
    end
  endgenerate

  // Entering scan from manual (or reset) restarts the pointer at channel 0.
  assign w_cur_ptr    = r_scan_prev ? r_ptr   : '0;
  assign w_cur_dwell  = r_scan_prev ? r_dwell : '0;
  assign w_cur_masked = skip_mask[w_cur_ptr];
  assign w_advance    = w_cur_masked || (w_cur_dwell == C_DWELL_LAST);
  assign w_s_ok       = ({1'b0, S} < C_N_CH);

  // Circular search from ptr+1; the current channel itself is the last candidate.
  always_comb begin
    w_idx   = '0;
    w_nxt   = w_cur_ptr;
    w_found = 1'b0;
    for (int k = N_CH; k >= 1; k--) begin
      w_idx = {1'b0, w_cur_ptr} + (SEL_W+1)'(k);
      if (w_idx >= C_N_CH) begin
        w_idx = w_idx - C_N_CH;
      end
      if (!skip_mask[w_idx[SEL_W-1:0]]) begin
        w_nxt   = w_idx[SEL_W-1:0];
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y          <= '0;
      r_y_valid    <= 1'b0;
      r_ch         <= '0;
      r_frame_done <= 1'b0;
      r_ptr        <= '0;
      r_dwell      <= '0;
      r_scan_prev  <= 1'b0;
    end else if (!en) begin
      r_frame_done <= 1'b0;
    end else if (!mode) begin
      r_y          <= w_s_ok ? w_ch[S] : '0;
      r_y_valid    <= w_s_ok;
      r_ch         <= S;
      r_frame_done <= 1'b0;
      r_scan_prev  <= 1'b0;
    end else begin
      r_scan_prev <= 1'b1;
      if (!w_found) begin
        // Every channel masked: park the scan, keep the last data.
        r_y_valid    <= 1'b0;
        r_ptr        <= w_cur_ptr;
        r_dwell      <= '0;
        r_frame_done <= 1'b0;
      end else begin
        r_y       <= w_ch[w_cur_ptr];
        r_ch      <= w_cur_ptr;
        r_y_valid <= ~w_cur_masked;
        if (w_advance) begin
          r_ptr        <= w_nxt;
          r_dwell      <= '0;
          r_frame_done <= (w_nxt <= w_cur_ptr);
        end else begin
          r_ptr        <= w_cur_ptr;
          r_dwell      <= w_cur_dwell + 8'd1;
          r_frame_done <= 1'b0;
        end
      end
    end
  end

  assign Y          = r_y;
  assign Y_valid    = r_y_valid;
  assign ch_out     = r_ch;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_seq
// Description : Directed self-checking bench for mux_scan_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_seq;

  logic        clk;
  logic        rst;
  logic        en;
  logic        mode;
  logic [15:0] d16;
  logic [3:0]  s16;
  logic [15:0] mask16;
  logic [4:0]  d5;
  logic [2:0]  s5;
  logic [4:0]  mask5;

  logic       y_a, yv_a, fd_a;
  logic [3:0] ch_a;
  logic       y_b, yv_b, fd_b;
  logic [3:0] ch_b;
  logic       y_c, yv_c, fd_c;
  logic [2:0] ch_c;

  int n_tests = 0;
  int n_fail  = 0;

  // a: 16 ch, dwell 1   b: 16 ch, dwell 3   c: 5 ch, dwell 1
  mux_scan_seq #(.N_CH(16), .W(1), .SEL_W(4), .DWELL(1)) u_dut_a (
    .clk(clk), .rst(rst), .D(d16), .S(s16), .mode(mode), .en(en),
    .skip_mask(mask16), .Y(y_a), .Y_valid(yv_a), .ch_out(ch_a), .frame_done(fd_a));

  mux_scan_seq #(.N_CH(16), .W(1), .SEL_W(4), .DWELL(3)) u_dut_b (
    .clk(clk), .rst(rst), .D(d16), .S(s16), .mode(mode), .en(en),
    .skip_mask(mask16), .Y(y_b), .Y_valid(yv_b), .ch_out(ch_b), .frame_done(fd_b));

  mux_scan_seq #(.N_CH(5), .W(1), .SEL_W(3), .DWELL(1)) u_dut_c (
    .clk(clk), .rst(rst), .D(d5), .S(s5), .mode(mode), .en(en),
    .skip_mask(mask5), .Y(y_c), .Y_valid(yv_c), .ch_out(ch_c), .frame_done(fd_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart_scan_b(input logic [15:0] m);
    mode = 1'b0;
    tick();
    mask16 = m;
    mode   = 1'b1;
  endtask

  initial begin
    int ch;
    rst    = 1'b1;
    en     = 1'b1;
    mode   = 1'b1;
    d16    = 16'b1001101001101001;
    s16    = '0;
    mask16 = '0;
    d5     = 5'b10110;
    s5     = '0;
    mask5  = '0;

    // Reset
    tick();
    tick();
    check_eq("rst_y",  y_a,  0);
    check_eq("rst_yv", yv_a, 0);
    check_eq("rst_ch", ch_a, 0);
    check_eq("rst_fd", fd_a, 0);
    check_eq("rst_b_ch", ch_b, 0);
    check_eq("rst_c_yv", yv_c, 0);

    // Manual select
    rst  = 1'b0;
    mode = 1'b0;
    s16 = 4'd1;  tick(); check_eq("man_s1_y",  y_a, 0); check_eq("man_s1_ch",  ch_a, 1);  check_eq("man_s1_yv", yv_a, 1);
    s16 = 4'd5;  tick(); check_eq("man_s5_y",  y_a, 1); check_eq("man_s5_ch",  ch_a, 5);  check_eq("man_s5_fd", fd_a, 0);
    s16 = 4'd9;  tick(); check_eq("man_s9_y",  y_a, 1); check_eq("man_s9_ch",  ch_a, 9);
    s16 = 4'd10; tick(); check_eq("man_s10_y", y_a, 0); check_eq("man_s10_ch", ch_a, 10); check_eq("man_s10_yv", yv_a, 1);

    // Scan, dwell 1, nothing masked
    mode = 1'b1;
    for (int i = 0; i < 33; i++) begin
      tick();
      ch = i % 16;
      check_eq($sformatf("scan1_ch_%0d", i), ch_a, ch);
      check_eq($sformatf("scan1_y_%0d", i),  y_a,  d16[ch]);
      check_eq($sformatf("scan1_fd_%0d", i), fd_a, (ch == 15) ? 1 : 0);
    end

    // Scan, dwell 3, channels 4..15 masked
    restart_scan_b(16'hFFF0);
    for (int i = 0; i < 25; i++) begin
      tick();
      ch = (i / 3) % 4;
      check_eq($sformatf("scan3_ch_%0d", i), ch_b, ch);
      check_eq($sformatf("scan3_yv_%0d", i), yv_b, 1);
      check_eq($sformatf("scan3_fd_%0d", i), fd_b, ((i % 12) == 11) ? 1 : 0);
    end

    // Hold with en low at channel 7, then resume the remaining dwell
    restart_scan_b(16'h0000);
    for (int i = 0; i < 22; i++) tick();
    check_eq("hold_pre_ch", ch_b, 7);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq($sformatf("hold_ch_%0d", i), ch_b, 7);
      check_eq($sformatf("hold_y_%0d", i),  y_b,  d16[7]);
      check_eq($sformatf("hold_fd_%0d", i), fd_b, 0);
    end
    en = 1'b1;
    tick(); check_eq("resume_ch0", ch_b, 7);
    tick(); check_eq("resume_ch1", ch_b, 7);
    tick(); check_eq("resume_ch2", ch_b, 8);
    tick(); tick(); tick();
    check_eq("pre_rst_ch", ch_b, 9);
    rst = 1'b1;
    tick();
    check_eq("midrst_ch", ch_b, 0);
    check_eq("midrst_yv", yv_b, 0);
    check_eq("midrst_y",  y_b,  0);
    rst = 1'b0;

    // All channels masked
    mask16 = 16'hFFFF;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq($sformatf("allmask_a_yv_%0d", i), yv_a, 0);
      check_eq($sformatf("allmask_a_fd_%0d", i), fd_a, 0);
      check_eq($sformatf("allmask_b_fd_%0d", i), fd_b, 0);
    end
    check_eq("allmask_ch_hold", ch_a, 0);

    // Single unmasked channel (5): frame pulse every dwell period
    restart_scan_b(16'hFFDF);
    tick();
    check_eq("single_first_ch", ch_b, 0);
    check_eq("single_first_yv", yv_b, 0);
    check_eq("single_first_fd", fd_b, 0);
    for (int i = 1; i < 8; i++) begin
      tick();
      check_eq($sformatf("single_ch_%0d", i), ch_b, 5);
      check_eq($sformatf("single_fd_%0d", i), fd_b, ((i % 3) == 0) ? 1 : 0);
    end

    // Mask the channel currently dwelling
    restart_scan_b(16'h0000);
    for (int i = 0; i < 7; i++) tick();
    check_eq("midmask_pre_ch", ch_b, 2);
    mask16 = 16'h0004;
    tick();
    check_eq("midmask_yv_low", yv_b, 0);
    tick();
    check_eq("midmask_next_ch", ch_b, 3);
    check_eq("midmask_next_yv", yv_b, 1);

    // N_CH = 5: out-of-range manual select and non-power-of-2 wrap
    mode = 1'b0;
    s5 = 3'd6; tick(); check_eq("n5_s6_y", y_c, 0); check_eq("n5_s6_yv", yv_c, 0);
    s5 = 3'd4; tick(); check_eq("n5_s4_y", y_c, 1); check_eq("n5_s4_yv", yv_c, 1);
    s5 = 3'd5; tick(); check_eq("n5_s5_yv", yv_c, 0);
    s5 = 3'd0; tick(); check_eq("n5_s0_y", y_c, 0); check_eq("n5_s0_ch", ch_c, 0);
    mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      ch = i % 5;
      check_eq($sformatf("n5_scan_ch_%0d", i), ch_c, ch);
      check_eq($sformatf("n5_scan_y_%0d", i),  y_c,  d5[ch]);
      check_eq($sformatf("n5_scan_fd_%0d", i), fd_c, (ch == 4) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_scan_seq.md
Name: mux_scan_seq

Overview:
Parametrised, registered N-channel, W-bit multiplexer with two modes: manual select and automatic round-robin channel scan.
- Scan mode has a programmable dwell time and a per-channel skip mask, and marks each completed frame.
- Successor to the combinational 16:1 mux; used as a time-division serializer ahead of shared output logic.

Parameters:
N_CH, 16, number of input channels (2..64).
W, 1, bit width of each channel.
SEL_W, 4, select/pointer width; must equal ceil(log2(N_CH)).
DWELL, 1, cycles spent on each channel in scan mode (1..255).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
D  in  N_CH*W  channel data; channel k occupies D[k*W +: W].
S  in  SEL_W  manual channel select.
mode  in  1  0 = manual, 1 = scan.
en  in  1  enable; when low, all outputs and state hold.
skip_mask  in  N_CH  bit k = 1 excludes channel k from scan (ignored in manual mode).
Y  out  W  registered selected channel data.
Y_valid  out  1  Y holds valid data this cycle.
ch_out  out  SEL_W  index of the channel currently on Y.
frame_done  out  1  one-cycle pulse when the scan wraps.

Behaviour:
- Reset (synchronous, active-high, wins over every other input): Y=0, Y_valid=0, ch_out=0, frame_done=0, ptr=0, dwell_cnt=0.
- en=0: every register holds, including ptr and dwell_cnt. frame_done is forced to 0.
- Manual mode (mode=0, en=1), 1-cycle latency:
  - Y <= D[S*W +: W], ch_out <= S, Y_valid <= 1.
  - If S >= N_CH: Y <= 0 and Y_valid <= 0.
  - frame_done stays 0.
- Scan mode (mode=1, en=1):
  - Each cycle: Y <= D[ptr*W +: W], ch_out <= ptr, Y_valid <= ~skip_mask[ptr].
  - dwell_cnt counts 0..DWELL-1.
  - When dwell_cnt = DWELL-1, or when skip_mask[ptr] = 1 (immediate skip), ptr advances to the next unmasked index, searched circularly from ptr+1, and dwell_cnt resets to 0.
  - frame_done <= 1 for one cycle when the advance wraps, i.e. next index <= current index.
- All channels masked in scan mode: Y_valid=0, ptr holds, dwell_cnt holds at 0, frame_done=0, Y holds its last value.
- Exactly one channel unmasked: ptr stays on it; frame_done pulses every DWELL cycles.
- Mode change manual -> scan: on the first scan cycle, ptr and dwell_cnt load 0. If channel 0 is masked, it is skipped on that cycle as above.
- Mode change scan -> manual: takes effect on the next edge; ptr is preserved but unused.
- skip_mask changes mid-dwell: take effect on the next edge. If the current channel becomes masked, Y_valid goes low and ptr advances that same edge.
- ptr arithmetic is modulo N_CH. For non-power-of-2 N_CH, ptr never holds a value >= N_CH.
- D is sampled on the same edge that captures Y. There is no input registering.

Test Plan:
1. Reset: assert rst for 2 cycles with mode=1, en=1 -> Y=0, Y_valid=0, ch_out=0, frame_done=0.
2. Manual, N_CH=16, W=1, D=16'b1001101001101001: S=1 -> Y=0; S=5 -> Y=1; S=9 -> Y=1; S=10 -> Y=0. Each result appears one cycle after S changes, with ch_out equal to S and Y_valid=1.
3. Scan, DWELL=1, skip_mask=0, same D: ch_out sequence is 0,1,...,15,0. Y sequence is 1,0,0,1,0,1,1,0,0,1,0,1,1,0,0,1. frame_done pulses once on the 15->0 wrap, every 16 cycles.
4. Scan, DWELL=3, skip_mask=16'hFFF0: ch_out = 0,0,0,1,1,1,2,2,2,3,3,3,0. frame_done pulses once per 12 cycles. Channels 4..15 never appear on ch_out.
5. Hold and reset mid-operation:
   - In scan, drop en for 5 cycles at ch_out=7 -> outputs are frozen and the scan resumes at 7 with the remaining dwell.
   - Assert rst at ch_out=9 -> next cycle ch_out=0, Y_valid=0.
6. Boundaries:
   - skip_mask=16'hFFFF -> Y_valid stays 0 and frame_done never pulses.
   - N_CH=5, SEL_W=3, manual S=6 -> Y=0, Y_valid=0.
   - Setting skip_mask bit 2 while dwelling on channel 2 -> the next cycle shows ch_out=3.
